// File: rtl/otp_ctrl_chk_sched.sv
// Background check scheduler: per-channel period counters, round-robin grant, shared watchdog, EDN-reseeded LFSR.
// Optional OTP_CHK_SCHED_REDUN_EN adds a lockstep shadow LFSR whose divergence forces ErrorSt.
module otp_ctrl_chk_sched #(
    parameter int unsigned NumChk = 3,
    parameter int unsigned NumPart = 8,
    parameter int unsigned LfsrWidth = 40,
    parameter int unsigned ReseedThresh = 256,
    parameter logic [LfsrWidth-1:0] LfsrSeed = 40'h5A_C3A5_96E1,
    localparam int unsigned ChanW = (NumChk > 1) ? $clog2(NumChk) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        timer_en_i,
    output logic                        edn_req_o,
    input  logic                        edn_ack_i,
    input  logic [LfsrWidth-1:0]        edn_data_i,
    input  logic [NumChk-1:0]           chk_trig_i,
    input  logic [32*NumChk-1:0]        period_msk_i,
    input  logic [31:0]                 timeout_i,
    input  logic [NumChk-1:0]           pause_i,
    output logic [NumChk*NumPart-1:0]   chk_req_o,
    input  logic [NumChk*NumPart-1:0]   chk_ack_i,
    output logic [NumChk-1:0]           chk_active_o,
    output logic                        chk_pending_o,
    output logic                        chk_timeout_o,
    output logic [ChanW-1:0]            timeout_chan_o,
    input  logic                        escalate_i,
    output logic                        fsm_err_o
);

    localparam int unsigned CntW = $clog2(ReseedThresh + 1);

    // Pairwise Hamming distance >= 3 between all four codes.
    typedef enum logic [4:0] {
        ResetSt = 5'b10100,
        IdleSt  = 5'b01110,
        WaitSt  = 5'b11011,
        ErrorSt = 5'b00001
    } state_e;

    function automatic logic [63:0] tap(input int unsigned n);
        return 64'd1 << (n - 1);
    endfunction

    // Maximal-length tap sets for widths 33..48; anything else falls back to the 64-bit set.
    function automatic logic [63:0] lfsr_poly(input int unsigned w);
        case (w)
            33: return tap(33) | tap(20);
            34: return tap(34) | tap(27) | tap(2) | tap(1);
            35: return tap(35) | tap(33);
            36: return tap(36) | tap(25);
            37: return tap(37) | tap(5) | tap(4) | tap(3) | tap(2) | tap(1);
            38: return tap(38) | tap(6) | tap(5) | tap(1);
            39: return tap(39) | tap(35);
            40: return tap(40) | tap(38) | tap(21) | tap(19);
            41: return tap(41) | tap(38);
            42: return tap(42) | tap(41) | tap(20) | tap(19);
            43: return tap(43) | tap(42) | tap(38) | tap(37);
            44: return tap(44) | tap(43) | tap(18) | tap(17);
            45: return tap(45) | tap(44) | tap(42) | tap(41);
            46: return tap(46) | tap(45) | tap(26) | tap(25);
            47: return tap(47) | tap(42);
            48: return tap(48) | tap(47) | tap(21) | tap(20);
            default: return tap(64) | tap(63) | tap(61) | tap(60);
        endcase
    endfunction

    localparam logic [63:0] PolyFull = lfsr_poly(LfsrWidth);
    localparam logic [LfsrWidth-1:0] LfsrPoly = PolyFull[LfsrWidth-1:0];

    function automatic logic [LfsrWidth-1:0] lfsr_step(input logic [LfsrWidth-1:0] s);
        return (s >> 1) ^ (s[0] ? LfsrPoly : '0);
    endfunction

    state_e                      state_q;
    logic                        en_q;
    logic [ChanW-1:0]            load_idx_q;
    logic [LfsrWidth-1:0]        per_cnt_q [NumChk];
    logic [NumChk-1:0]           due_q, trig_q, active_q;
    logic [NumChk*NumPart-1:0]   req_q;
    logic [ChanW-1:0]            last_grant_q, timeout_chan_q;
    logic [31:0]                 wdog_q;
    logic                        timeout_q, fsm_err_q;
    logic [LfsrWidth-1:0]        lfsr_q, lfsr_nxt, lfsr_stepped;
    logic [CntW-1:0]             draw_cnt_q;

    logic                        reseed, draw, lfsr_fault, wdog_hit, pause_act;
    logic [NumChk-1:0]           pend, due_set, gnt_onehot, trig_nxt, due_nxt;
    logic                        gnt_vld;
    logic [ChanW-1:0]            gnt_idx, cand_idx;
    int unsigned                 cand;
    logic [NumChk*NumPart-1:0]   gnt_req, req_acked;
    logic [LfsrWidth-1:0]        msk_full [NumChk];

    assign edn_req_o = (draw_cnt_q >= CntW'(ReseedThresh));
    assign reseed    = edn_req_o & edn_ack_i;
    assign pend      = due_q | trig_q;
    assign pause_act = pause_i[last_grant_q];
    assign wdog_hit  = (timeout_i != '0) && (wdog_q == '0);
    assign req_acked = req_q & ~chk_ack_i;

    // A draw happens on each serialised initial load and on each completed check.
    assign draw = ((state_q == ResetSt) && (en_q || timer_en_i)) ||
                  ((state_q == WaitSt) && !wdog_hit && (req_acked == '0));

    assign lfsr_stepped = lfsr_step(lfsr_q) ^ (reseed ? edn_data_i : '0);
    always_comb begin
        lfsr_nxt = lfsr_q;
        if (draw || reseed) begin
            lfsr_nxt = (reseed && (lfsr_stepped == '0)) ? LfsrSeed : lfsr_stepped;
        end
    end

`ifdef OTP_CHK_SCHED_REDUN_EN
    logic [LfsrWidth-1:0] lfsr_shadow_q, shadow_stepped, shadow_nxt;

    assign shadow_stepped = lfsr_step(lfsr_shadow_q) ^ (reseed ? edn_data_i : '0);
    always_comb begin
        shadow_nxt = lfsr_shadow_q;
        if (draw || reseed) begin
            shadow_nxt = (reseed && (shadow_stepped == '0)) ? LfsrSeed : shadow_stepped;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lfsr_shadow_q <= LfsrSeed;
        end else begin
            lfsr_shadow_q <= shadow_nxt;
        end
    end

    assign lfsr_fault = (lfsr_shadow_q != lfsr_q);
`else
    assign lfsr_fault = 1'b0;
`endif

    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NumChk; i++) begin
            cand     = (int'(last_grant_q) + 1 + i) % NumChk;
            cand_idx = ChanW'(cand);
            if (!gnt_vld && pend[cand_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand_idx;
            end
        end
    end

    // The channel under check is excluded from due: its counter sits at 0 until the completion reload.
    always_comb begin
        for (int c = 0; c < NumChk; c++) begin
            msk_full[c]   = {period_msk_i[32*c +: 32], {(LfsrWidth-32){1'b1}}};
            gnt_onehot[c] = gnt_vld && (gnt_idx == ChanW'(c));
            gnt_req[c*NumPart +: NumPart] = {NumPart{gnt_onehot[c]}};
            due_set[c]    = ((state_q == IdleSt) || (state_q == WaitSt)) &&
                            (per_cnt_q[c] == '0) && (period_msk_i[32*c +: 32] != '0) &&
                            !((state_q == WaitSt) && (last_grant_q == ChanW'(c)));
        end
        trig_nxt = trig_q | chk_trig_i;
        due_nxt  = due_q | due_set;
        if ((state_q == IdleSt) && gnt_vld) begin
            trig_nxt = (trig_q & ~gnt_onehot) | chk_trig_i;
            due_nxt  = (due_q | due_set) & ~gnt_onehot;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q        <= ResetSt;
            en_q           <= 1'b0;
            load_idx_q     <= '0;
            for (int c = 0; c < NumChk; c++) per_cnt_q[c] <= '0;
            due_q          <= '0;
            trig_q         <= '0;
            active_q       <= '0;
            req_q          <= '0;
            last_grant_q   <= '0;
            timeout_chan_q <= '0;
            wdog_q         <= '0;
            timeout_q      <= 1'b0;
            fsm_err_q      <= 1'b0;
            lfsr_q         <= LfsrSeed;
            draw_cnt_q     <= '0;
        end else begin
            lfsr_q <= lfsr_nxt;
            en_q   <= en_q | timer_en_i;
            if (reseed) begin
                draw_cnt_q <= '0;
            end else if (draw && !edn_req_o) begin
                draw_cnt_q <= draw_cnt_q + CntW'(1);
            end

            if (escalate_i || lfsr_fault) begin
                state_q   <= ErrorSt;
                fsm_err_q <= 1'b1;
                req_q     <= '0;
                trig_q    <= '0;
                due_q     <= '0;
                active_q  <= '0;
            end else begin
                unique case (state_q)
                    ResetSt: begin
                        trig_q <= trig_q | chk_trig_i;
                        if (en_q || timer_en_i) begin
                            per_cnt_q[load_idx_q] <= lfsr_q & msk_full[load_idx_q];
                            if (load_idx_q == ChanW'(NumChk - 1)) begin
                                load_idx_q <= '0;
                                state_q    <= IdleSt;
                            end else begin
                                load_idx_q <= load_idx_q + ChanW'(1);
                            end
                        end
                    end
                    IdleSt: begin
                        trig_q <= trig_nxt;
                        due_q  <= due_nxt;
                        for (int c = 0; c < NumChk; c++) begin
                            if (per_cnt_q[c] != '0) per_cnt_q[c] <= per_cnt_q[c] - LfsrWidth'(1);
                        end
                        if (gnt_vld) begin
                            req_q        <= gnt_req;
                            active_q     <= gnt_onehot;
                            last_grant_q <= gnt_idx;
                            wdog_q       <= timeout_i;
                            state_q      <= WaitSt;
                        end
                    end
                    WaitSt: begin
                        trig_q <= trig_nxt;
                        due_q  <= due_nxt;
                        req_q  <= req_acked;
                        for (int c = 0; c < NumChk; c++) begin
                            if (per_cnt_q[c] != '0) per_cnt_q[c] <= per_cnt_q[c] - LfsrWidth'(1);
                        end
                        if (!pause_act && (wdog_q != '0)) wdog_q <= wdog_q - 32'd1;
                        // Timeout takes priority over a final ack landing in the same cycle.
                        if (wdog_hit) begin
                            state_q        <= ErrorSt;
                            timeout_q      <= 1'b1;
                            timeout_chan_q <= last_grant_q;
                            req_q          <= '0;
                            trig_q         <= '0;
                            due_q          <= '0;
                            active_q       <= '0;
                        end else if (req_acked == '0) begin
                            per_cnt_q[last_grant_q] <= lfsr_q & msk_full[last_grant_q];
                            active_q <= '0;
                            state_q  <= IdleSt;
                        end
                    end
                    ErrorSt: begin
                        req_q    <= '0;
                        trig_q   <= '0;
                        due_q    <= '0;
                        active_q <= '0;
                    end
                    default: begin
                        state_q   <= ErrorSt;
                        fsm_err_q <= 1'b1;
                        req_q     <= '0;
                        trig_q    <= '0;
                        due_q     <= '0;
                        active_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign chk_req_o      = req_q;
    assign chk_active_o   = active_q;
    assign chk_pending_o  = (|active_q) | (|trig_q) | (|due_q);
    assign chk_timeout_o  = timeout_q;
    assign timeout_chan_o = timeout_chan_q;
    assign fsm_err_o      = fsm_err_q;

endmodule

// File: tb/tb_otp_ctrl_chk_sched.sv
// Scoreboard bench for otp_ctrl_chk_sched: grant order, watchdog/pause timing, reseed, escalation, reset.
module tb_otp_ctrl_chk_sched;
    localparam int NC = 3;
    localparam int NP = 8;
    localparam int LW = 40;
    localparam logic [LW-1:0] SEED = 40'h5A_C3A5_96E1;
    localparam logic [LW-1:0] TAPS = 40'hA0_0014_0000;

    logic              clk = 1'b0;
    logic              rst;
    logic              timer_en;
    logic              edn_req;
    logic              edn_ack;
    logic [LW-1:0]     edn_data;
    logic [NC-1:0]     chk_trig;
    logic [32*NC-1:0]  period_msk;
    logic [31:0]       timeout;
    logic [NC-1:0]     pause;
    logic [NC*NP-1:0]  chk_req;
    logic [NC*NP-1:0]  chk_ack;
    logic [NC-1:0]     chk_active;
    logic              chk_pending;
    logic              chk_timeout;
    logic [1:0]        timeout_chan;
    logic              escalate;
    logic              fsm_err;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];

    otp_ctrl_chk_sched #(
        .NumChk(NC), .NumPart(NP), .LfsrWidth(LW), .ReseedThresh(4), .LfsrSeed(SEED)
    ) dut (
        .clk_i(clk), .rst_i(rst), .timer_en_i(timer_en), .edn_req_o(edn_req),
        .edn_ack_i(edn_ack), .edn_data_i(edn_data), .chk_trig_i(chk_trig),
        .period_msk_i(period_msk), .timeout_i(timeout), .pause_i(pause),
        .chk_req_o(chk_req), .chk_ack_i(chk_ack), .chk_active_o(chk_active),
        .chk_pending_o(chk_pending), .chk_timeout_o(chk_timeout),
        .timeout_chan_o(timeout_chan), .escalate_i(escalate), .fsm_err_o(fsm_err)
    );

    always #5 clk = ~clk;

    function automatic logic [LW-1:0] mstep(input logic [LW-1:0] s);
        logic [LW-1:0] n;
        n = {1'b0, s[LW-1:1]};
        if (s[0]) n = n ^ TAPS;
        return n;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; timer_en = 1'b0; edn_ack = 1'b0; edn_data = '0; chk_trig = '0;
        period_msk = '0; timeout = '0; pause = '0; chk_ack = '0; escalate = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic enable();
        timer_en = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_grant();
        for (int i = 0; i < 20 && chk_active == '0; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors += 7;
        if (chk_req !== '0) begin miscompares++; $display("FAIL reset_req: got %h want 0", chk_req); end
        if (chk_active !== '0) begin miscompares++; $display("FAIL reset_active: got %b want 0", chk_active); end
        if (chk_pending !== 1'b0) begin miscompares++; $display("FAIL reset_pending: got %b want 0", chk_pending); end
        if (chk_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_timeout: got %b want 0", chk_timeout); end
        if (timeout_chan !== '0) begin miscompares++; $display("FAIL reset_tchan: got %0d want 0", timeout_chan); end
        if (fsm_err !== 1'b0) begin miscompares++; $display("FAIL reset_fsm_err: got %b want 0", fsm_err); end
        if (edn_req !== 1'b0) begin miscompares++; $display("FAIL reset_edn_req: got %b want 0", edn_req); end
    endtask

    task automatic test_round_robin();
        logic [NC*NP-1:0] base, exp_req;
        logic [NC-1:0] prev_act, exp_act;
        int e, budget;
        do_reset();
        enable();
        exp_q.delete();
        chk_trig = 3'b111;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        @(negedge clk);
        chk_trig = '0;
        prev_act = '0;
        budget = 0;
        base = 24'hFF;
        while (exp_q.size() > 0 && budget < 200) begin
            @(negedge clk);
            budget++;
            if (chk_active != '0 && prev_act == '0) begin
                e = exp_q.pop_front();
                exp_act = 3'b001 << e;
                exp_req = base << (NP * e);
                vectors += 4;
                if (chk_active !== exp_act) begin miscompares++; $display("FAIL rr_grant: got %b want %b", chk_active, exp_act); end
                if (chk_req !== exp_req) begin miscompares++; $display("FAIL rr_req: got %h want %h", chk_req, exp_req); end
                chk_ack = exp_req & 24'h0F0F0F;
                @(negedge clk);
                chk_ack = '0;
                if (chk_req !== (exp_req & 24'hF0F0F0)) begin
                    miscompares++; $display("FAIL rr_partial: got %h want %h", chk_req, exp_req & 24'hF0F0F0);
                end
                chk_ack = exp_req;
                @(negedge clk);
                chk_ack = '0;
                if (chk_active !== '0) begin miscompares++; $display("FAIL rr_release: got %b want 0", chk_active); end
            end
            prev_act = chk_active;
        end
        vectors += 2;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL rr_done: %0d grants missing", exp_q.size()); end
        if (chk_pending !== 1'b0) begin miscompares++; $display("FAIL rr_pending: got %b want 0", chk_pending); end
    endtask

    task automatic test_trig_regrant();
        logic [NC-1:0] prev_act;
        int e, budget;
        do_reset();
        enable();
        exp_q.delete();
        chk_trig = 3'b010;
        exp_q.push_back(1);
        @(negedge clk);
        chk_trig = 3'b010;
        exp_q.push_back(1);
        @(negedge clk);
        chk_trig = '0;
        prev_act = '0;
        budget = 0;
        while (exp_q.size() > 0 && budget < 100) begin
            if (chk_active != '0 && prev_act == '0) begin
                e = exp_q.pop_front();
                vectors++;
                if (chk_active !== (3'b001 << e)) begin miscompares++; $display("FAIL regrant: got %b want %b", chk_active, 3'b001 << e); end
                chk_ack = chk_req;
            end
            prev_act = chk_active;
            @(negedge clk);
            chk_ack = '0;
            budget++;
        end
        repeat (3) @(negedge clk);
        vectors += 2;
        if (exp_q.size() != 0) begin miscompares++; $display("FAIL regrant_done: %0d grants missing", exp_q.size()); end
        if (chk_pending !== 1'b0) begin miscompares++; $display("FAIL regrant_pending: got %b want 0", chk_pending); end
    endtask

    task automatic test_watchdog(input int pause_cycles, input int exp_cycles);
        int cnt;
        do_reset();
        enable();
        timeout = 32'd20;
        chk_trig = 3'b100;
        @(negedge clk);
        chk_trig = '0;
        wait_grant();
        vectors++;
        if (chk_active !== 3'b100) begin miscompares++; $display("FAIL wd_grant: got %b want 100", chk_active); end
        if (pause_cycles > 0) pause = 3'b100;
        cnt = 0;
        while (!chk_timeout && cnt < 100) begin
            @(negedge clk);
            cnt++;
            if (cnt == pause_cycles) pause = '0;
        end
        vectors += 4;
        if (cnt != exp_cycles) begin miscompares++; $display("FAIL wd_latency(pause=%0d): got %0d want %0d", pause_cycles, cnt, exp_cycles); end
        if (timeout_chan !== 2'd2) begin miscompares++; $display("FAIL wd_chan: got %0d want 2", timeout_chan); end
        if (fsm_err !== 1'b0) begin miscompares++; $display("FAIL wd_fsm_err: got %b want 0", fsm_err); end
        if (chk_req !== '0) begin miscompares++; $display("FAIL wd_req: got %h want 0", chk_req); end
    endtask

    task automatic test_reseed();
        logic [LW-1:0] m;
        do_reset();
        period_msk = {32'h0, 32'h0, 32'hF};
        enable();
        m = mstep(mstep(mstep(SEED)));
        vectors += 2;
        if (edn_req !== 1'b0) begin miscompares++; $display("FAIL rs_req_init: got %b want 0", edn_req); end
        if (dut.lfsr_q !== m) begin miscompares++; $display("FAIL rs_lfsr_init: got %h want %h", dut.lfsr_q, m); end
        for (int i = 0; i < 5000 && chk_active == '0; i++) @(negedge clk);
        vectors += 2;
        if (chk_active !== 3'b001) begin miscompares++; $display("FAIL rs_due_grant: got %b want 001", chk_active); end
        if (edn_req !== 1'b0) begin miscompares++; $display("FAIL rs_req_pre: got %b want 0", edn_req); end
        chk_ack = chk_req;
        @(negedge clk);
        chk_ack = '0;
        m = mstep(m);
        vectors += 2;
        if (edn_req !== 1'b1) begin miscompares++; $display("FAIL rs_req_rise: got %b want 1", edn_req); end
        if (dut.lfsr_q !== m) begin miscompares++; $display("FAIL rs_lfsr_4: got %h want %h", dut.lfsr_q, m); end
        edn_ack = 1'b1;
        edn_data = 40'h1;
        @(negedge clk);
        edn_ack = 1'b0;
        edn_data = '0;
        m = mstep(m) ^ 40'h1;
        vectors += 2;
        if (dut.lfsr_q !== m) begin miscompares++; $display("FAIL rs_lfsr_reseed: got %h want %h", dut.lfsr_q, m); end
        if (edn_req !== 1'b0) begin miscompares++; $display("FAIL rs_req_clear: got %b want 0", edn_req); end
    endtask

    task automatic test_escalate();
        do_reset();
        enable();
        chk_trig = 3'b010;
        @(negedge clk);
        chk_trig = '0;
        wait_grant();
        escalate = 1'b1;
        @(negedge clk);
        escalate = 1'b0;
        vectors += 4;
        if (chk_req !== '0) begin miscompares++; $display("FAIL esc_req: got %h want 0", chk_req); end
        if (fsm_err !== 1'b1) begin miscompares++; $display("FAIL esc_fsm_err: got %b want 1", fsm_err); end
        if (chk_active !== '0) begin miscompares++; $display("FAIL esc_active: got %b want 0", chk_active); end
        if (chk_timeout !== 1'b0) begin miscompares++; $display("FAIL esc_timeout: got %b want 0", chk_timeout); end
    endtask

    task automatic test_reset_mid_wait();
        do_reset();
        enable();
        chk_trig = 3'b001;
        @(negedge clk);
        chk_trig = '0;
        wait_grant();
        vectors++;
        if (chk_active !== 3'b001) begin miscompares++; $display("FAIL rmw_grant: got %b want 001", chk_active); end
        rst = 1'b1;
        @(negedge clk);
        vectors += 3;
        if (chk_req !== '0) begin miscompares++; $display("FAIL rmw_req: got %h want 0", chk_req); end
        if (chk_active !== '0) begin miscompares++; $display("FAIL rmw_active: got %b want 0", chk_active); end
        if (chk_pending !== 1'b0) begin miscompares++; $display("FAIL rmw_pending: got %b want 0", chk_pending); end
        rst = 1'b0;
    endtask

`ifdef OTP_CHK_SCHED_REDUN_EN
    task automatic test_redun();
        do_reset();
        enable();
        force dut.lfsr_shadow_q = ~dut.lfsr_q;
        @(negedge clk);
        release dut.lfsr_shadow_q;
        vectors++;
        if (fsm_err !== 1'b1) begin miscompares++; $display("FAIL redun_fsm_err: got %b want 1", fsm_err); end
    endtask
`endif

    initial begin
        #2ms;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; timer_en = 1'b0; edn_ack = 1'b0; edn_data = '0; chk_trig = '0;
        period_msk = '0; timeout = '0; pause = '0; chk_ack = '0; escalate = 1'b0;
        test_reset();
        test_round_robin();
        test_trig_regrant();
        test_watchdog(0, 21);
        test_watchdog(10, 31);
        test_reseed();
        test_escalate();
        test_reset_mid_wait();
`ifdef OTP_CHK_SCHED_REDUN_EN
        test_redun();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/otp_ctrl_chk_sched.md
# otp_ctrl_chk_sched

Multi-channel successor to the OTP consistency/integrity check timer. It schedules periodic and one-off background checks for `NumChk` independent check types across `NumPart` partitions. Each channel has its own period counter, and all channels draw pseudo-random wait periods from a shared EDN-reseeded LFSR. A round-robin arbiter picks which due check is broadcast next, and a shared watchdog detects wedged partitions. The block sits between the OTP CSR/error logic and the partition controllers.

## Interface
- `NumChk`, 3, number of check channels (1..8).
- `NumPart`, 8, number of partitions receiving requests.
- `LfsrWidth`, 40, LFSR and counter width (>= 33).
- `ReseedThresh`, 256, LFSR draws before an EDN reseed is requested.
- `LfsrSeed`, `40'h5A_C3A5_96E1`, LFSR reset value (non-zero, `LfsrWidth` bits).

Ports:
- `clk_i` in 1: clock.
- `rst_i` in 1: synchronous, active-high reset.
- `timer_en_i` in 1: enable; sticky once seen.
- `edn_req_o` out 1: reseed request.
- `edn_ack_i` in 1: EDN acknowledge.
- `edn_data_i` in `LfsrWidth`: entropy, valid with `edn_ack_i`.
- `chk_trig_i` in `NumChk`: one-off trigger per channel, single-cycle pulses.
- `period_msk_i` in `32*NumChk`: per-channel period mask; channel c uses bits `[32c+31:32c]`; 0 disables periodic checks on that channel.
- `timeout_i` in 32: watchdog load value; 0 disables the watchdog.
- `pause_i` in `NumChk`: freezes the watchdog while the active channel's bit is high.
- `chk_req_o` out `NumChk*NumPart`: requests; channel c uses bits `[NumPart*c +: NumPart]`.
- `chk_ack_i` in `NumChk*NumPart`: acks, same layout as `chk_req_o`.
- `chk_active_o` out `NumChk`: one-hot active channel, 0 when idle.
- `chk_pending_o` out 1: a check is active, or any trigger or due flag is set.
- `chk_timeout_o` out 1: watchdog expired (sticky).
- `timeout_chan_o` out `$clog2(NumChk)` (min 1): channel that timed out.
- `escalate_i` in 1: forces ErrorSt.
- `fsm_err_o` out 1: internal fault or escalation.

## Operation
- States: ResetSt, IdleSt, WaitSt, ErrorSt. Sparse encoding, minimum Hamming distance 3; any invalid encoding goes to ErrorSt with `fsm_err_o`=1.
- **ResetSt**
  - On `timer_en_i`: go to IdleSt.
  - Every period counter c loads `lfsr & {msk_c, {LfsrWidth-32{1'b1}}}` in channel order. Each load is one LFSR step; steps are serialised, one per cycle, and the transition to IdleSt happens after the last load.
- **Period counters**
  - Decrement in IdleSt and WaitSt; saturate at 0.
  - `due_c` sets when the counter is 0 and `msk_c`≠0.
  - `trig_q[c]` sets on a `chk_trig_i[c]` pulse.
  - Both flags are sticky until channel c is granted.
- **IdleSt**: if any `due|trig` is set, round-robin grant starting at `last_grant+1` mod `NumChk`. On grant:
  - set all `NumPart` request bits of the granted channel;
  - clear its `due` and `trig` flags;
  - load the watchdog with `timeout_i`;
  - go to WaitSt.
- **WaitSt**
  - Request bit (c,p) clears on the cycle its ack is seen.
  - The watchdog decrements unless `pause_i[active]` is high.
  - If `timeout_i`≠0 and the watchdog is 0: go to ErrorSt, set `chk_timeout_o`, latch `timeout_chan_o`.
  - Otherwise, once all of the active channel's request bits are 0: reload that channel's period counter from a fresh LFSR draw and return to IdleSt.
- **ErrorSt**
  - Terminal.
  - Clears all requests, trigger flags and due flags.
  - `fsm_err_o`=1 unless the entry was a watchdog timeout.
- **Escalation and faults**: `escalate_i` or an LFSR fault takes any state to ErrorSt on the next cycle with `fsm_err_o`=1.
- **Reseed**
  - Draw counter increments per LFSR step and saturates at `ReseedThresh`.
  - `edn_req_o` = (count ≥ `ReseedThresh`).
  - On `edn_req_o & edn_ack_i`: state ← step(state) ^ `edn_data_i`, and the counter clears.
  - Draws continue while the request is pending; the counter does not increment while `edn_req_o` is high.
  - If the reseeded state is 0, `LfsrSeed` is substituted.
- **LFSR**: Galois, maximal-length polynomial for `LfsrWidth`.

## Timing
- Reset values:
  - all outputs 0, state ResetSt;
  - LFSR = `LfsrSeed`;
  - all counters, flags and `last_grant` = 0 (so the first grant starts at channel `1 % NumChk`).
- Trigger to request: `chk_trig_i` in cycle t; `trig_q` in t+1; the request is visible at `chk_req_o` in t+2 if IdleSt and granted.
- Ack in cycle t clears the request bit in t+1. Final ack in t: Idle and reload in t+1, next grant no earlier than t+2.
- Trigger arriving on the same cycle its flag clears (the grant): re-set, yielding one extra check later.
- Simultaneous `edn_ack_i` and a draw: one combined step with the XOR applied.
- Watchdog reaches 0 on the same cycle as the final ack: the timeout wins.
- `rst_i` mid-WaitSt: every output returns to its reset value on the next edge.

## Configuration
- `OTP_CHK_SCHED_REDUN_EN` defined:
  - a second LFSR runs in lockstep;
  - state mismatch on any cycle asserts the LFSR fault, giving ErrorSt with `fsm_err_o`=1.
- Undefined: single LFSR, fault tied to 0.

## Test plan
- **Round-robin**: `NumChk`=3, masks 0, `chk_trig_i`=3'b111 in one cycle. Grants go 1, 2, 0; each channel's requests are all 8 bits until acked.
- **Watchdog**: `timeout_i`=20, no acks. `chk_timeout_o`=1 and `timeout_chan_o`=granted channel 21 cycles after the grant; `fsm_err_o` stays 0.
- **Pause**: `timeout_i`=20 with `pause_i` high for 10 cycles. The timeout occurs 10 cycles later than without pause.
- **Reseed**: `ReseedThresh`=4, mask `32'hF`, acks returned immediately.
  - `edn_req_o` rises after the 4th draw.
  - Ack with data `40'h1`: next state = step ^ 1 and the counter clears.
- **Escalation mid-WaitSt**: `escalate_i` pulse. Next cycle: ErrorSt, `chk_req_o`=0, `fsm_err_o`=1.
- **With `OTP_CHK_SCHED_REDUN_EN`**: force a shadow-LFSR bit flip. ErrorSt next cycle, `fsm_err_o`=1.
